// File: rtl/sort_job_sched.sv
// sort_job_sched: round-robin scheduler sharing one NUM-slot sort engine between two requesters
module sort_job_sched #(
  parameter int DW  = 5,
  parameter int NUM = 10,
  parameter int TMO = 64
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req0_valid,
  input  logic          req0_last,
  input  logic [DW-1:0] req0_data,
  output logic          req0_ready,
  input  logic          req1_valid,
  input  logic          req1_last,
  input  logic [DW-1:0] req1_data,
  output logic          req1_ready,
  output logic          eng_in_valid1,
  output logic          eng_in_valid2,
  output logic [DW-1:0] eng_in,
  output logic          eng_mode,
  output logic [1:0]    eng_op,
  input  logic          eng_out_valid,
  input  logic [DW-1:0] eng_out,
  output logic          rsp_valid,
  output logic [DW-1:0] rsp_data,
  output logic          rsp_id,
  output logic          rsp_last,
  output logic          busy,
  output logic          err_tmo
);
  localparam int CW = $clog2(NUM + 1);
  localparam int TW = $clog2(TMO);
  typedef enum logic [2:0] {SETTLE, ARB, MODE, LOAD, START, WAIT, DRAIN} state_t;
  state_t state, state_n;
  logic owner, owner_n, rr, rr_n, acc, lst, g;
  logic [CW-1:0] cnt, cnt_n;
  logic [TW-1:0] tcnt, tcnt_n;
  logic iv1_n, iv2_n, rv_n, rl_n, err_n;
  logic [1:0] op_n;
  logic [DW-1:0] in_n, rd_n;
  assign eng_mode = 1'b0;
  // next state plus the engine/response strobes to register for the coming cycle
  always_comb begin
    acc = owner ? (req1_valid & req1_ready) : (req0_valid & req0_ready);
    lst = owner ? req1_last : req0_last;
    g = (req0_valid & req1_valid) ? rr : req1_valid;
    state_n = state;
    owner_n = owner;
    rr_n = rr;
    cnt_n = cnt;
    tcnt_n = tcnt;
    iv1_n = 1'b0;
    iv2_n = 1'b0;
    op_n = 2'd0;
    in_n = eng_in;
    rv_n = 1'b0;
    rd_n = rsp_data;
    rl_n = 1'b0;
    err_n = 1'b0;
    case (state)
      SETTLE: begin
        tcnt_n = (tcnt == TW'(1)) ? '0 : tcnt + 1'b1;
        state_n = (tcnt == TW'(1)) ? ARB : SETTLE;
      end
      ARB: if (req0_valid | req1_valid) begin
        owner_n = g;
        rr_n = ~g;
        state_n = MODE;
      end
      MODE: begin
        iv2_n = 1'b1;
        cnt_n = '0;
        state_n = LOAD;
      end
      LOAD: if (acc) begin
        iv1_n = 1'b1;
        op_n = 2'd1;
        in_n = owner ? req1_data : req0_data;
        cnt_n = cnt + 1'b1;
        state_n = (lst || cnt == CW'(NUM - 1)) ? START : LOAD;
      end
      START: begin
        iv1_n = 1'b1;
        op_n = 2'd2;
        cnt_n = '0;
        tcnt_n = '0;
        state_n = WAIT;
      end
      WAIT, DRAIN: if (eng_out_valid) begin
        rv_n = 1'b1;
        rd_n = eng_out;
        rl_n = cnt == CW'(NUM - 1);
        cnt_n = cnt + 1'b1;
        tcnt_n = '0;
        state_n = rl_n ? SETTLE : DRAIN;
      end else if (tcnt == TW'(TMO - 1)) begin
        err_n = 1'b1;
        tcnt_n = '0;
        state_n = SETTLE;
      end else begin
        tcnt_n = tcnt + 1'b1;
      end
      default: state_n = SETTLE;
    endcase
  end
  // state and registered outputs; ready and busy track the state being entered
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= SETTLE;
      owner <= 1'b0;
      rr <= 1'b0;
      cnt <= '0;
      tcnt <= '0;
      req0_ready <= 1'b0;
      req1_ready <= 1'b0;
      eng_in_valid1 <= 1'b0;
      eng_in_valid2 <= 1'b0;
      eng_in <= '0;
      eng_op <= 2'd0;
      rsp_valid <= 1'b0;
      rsp_data <= '0;
      rsp_id <= 1'b0;
      rsp_last <= 1'b0;
      busy <= 1'b0;
      err_tmo <= 1'b0;
    end else begin
      state <= state_n;
      owner <= owner_n;
      rr <= rr_n;
      cnt <= cnt_n;
      tcnt <= tcnt_n;
      req0_ready <= state_n == LOAD && !owner_n;
      req1_ready <= state_n == LOAD && owner_n;
      eng_in_valid1 <= iv1_n;
      eng_in_valid2 <= iv2_n;
      eng_in <= in_n;
      eng_op <= op_n;
      rsp_valid <= rv_n;
      rsp_data <= rd_n;
      rsp_id <= owner;
      rsp_last <= rl_n;
      busy <= state_n != ARB;
      err_tmo <= err_n;
    end
  end
endmodule

// File: tb/tb_sort_job_sched.sv
// tb_sort_job_sched: directed and randomized jobs against a sort/round-robin reference model
module tb_sort_job_sched;
  localparam int DW = 5;
  localparam int NUM = 10;
  logic clk, rst_n;
  logic req0_valid, req0_last, req0_ready, req1_valid, req1_last, req1_ready;
  logic [DW-1:0] req0_data, req1_data, eng_in, eng_out, rsp_data;
  logic eng_in_valid1, eng_in_valid2, eng_mode, eng_out_valid;
  logic [1:0] eng_op;
  logic rsp_valid, rsp_id, rsp_last, busy, err_tmo;
  int checks = 0, errors = 0;
  int push_q[$], eng_slots[$], rsp_d[$], rsp_i[$], rsp_l[$];
  bit rr_m;

  sort_job_sched dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_last(req0_last), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_last(req1_last), .req1_data(req1_data), .req1_ready(req1_ready),
    .eng_in_valid1(eng_in_valid1), .eng_in_valid2(eng_in_valid2), .eng_in(eng_in),
    .eng_mode(eng_mode), .eng_op(eng_op), .eng_out_valid(eng_out_valid), .eng_out(eng_out),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_id(rsp_id), .rsp_last(rsp_last),
    .busy(busy), .err_tmo(err_tmo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // engine slot model and capture of pushes and responses
  always @(negedge clk) begin
    if (eng_in_valid2) eng_slots.delete();
    if (eng_in_valid1 && eng_op == 2'd1) begin
      push_q.push_back(int'(eng_in));
      if (eng_slots.size() < NUM) eng_slots.push_back(int'(eng_in));
    end
    if (rsp_valid) begin
      rsp_d.push_back(int'(rsp_data));
      rsp_i.push_back(int'(rsp_id));
      rsp_l.push_back(int'(rsp_last));
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] outs();
    return 32'({req0_ready, req1_ready, eng_in_valid1, eng_in_valid2, eng_mode, eng_op, eng_in,
                rsp_valid, rsp_data, rsp_id, rsp_last, busy, err_tmo});
  endfunction

  function automatic bit arb(input bit v0, input bit v1);
    bit g = (v0 && v1) ? rr_m : v1;
    rr_m = !g;
    return g;
  endfunction

  task automatic drv(input bit who, input bit v, input int d, input bit l);
    if (who) begin req1_valid = v; req1_data = DW'(d); req1_last = l; end
    else begin req0_valid = v; req0_data = DW'(d); req0_last = l; end
  endtask

  task automatic clear_mon();
    push_q.delete();
    rsp_d.delete();
    rsp_i.delete();
    rsp_l.delete();
  endtask

  task automatic stream(input bit who, input int vals[$], input bit wl, input int gap_at, input int gap_len);
    int i = 0, n = 0, g = 0;
    bit rdy;
    while (i < vals.size() && n < 400) begin
      @(negedge clk);
      n++;
      if (gap_at > 0 && i == gap_at && g < gap_len) begin
        drv(who, 0, 0, 0);
        g++;
      end else begin
        rdy = who ? req1_ready : req0_ready;
        drv(who, 1, vals[i], wl && i == vals.size() - 1);
        if (rdy) i++;
      end
    end
    if (i < vals.size()) check("stream_accepts", i, vals.size());
    @(negedge clk);
    drv(who, 0, 0, 0);
  endtask

  task automatic engine_run(input int lat, input int gapk);
    int n = 0;
    int r[$];
    while (!(eng_in_valid1 && eng_op == 2'd2) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("sort_cmd", 32'(eng_in_valid1 && eng_op == 2'd2), 1);
    r = eng_slots;
    r.rsort();
    while (r.size() < NUM) r.push_back(0);
    repeat (lat) @(negedge clk);
    for (int k = 0; k < NUM; k++) begin
      if (gapk != 0 && k == gapk) begin
        eng_out_valid = 1'b0;
        repeat (3) @(negedge clk);
      end
      eng_out_valid = 1'b1;
      eng_out = r[k][DW-1:0];
      @(negedge clk);
    end
    eng_out_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic check_job(input bit owner, input int vals[$]);
    int e[$];
    e = vals;
    e.rsort();
    while (e.size() < NUM) e.push_back(0);
    check("push_cnt", push_q.size(), vals.size());
    for (int i = 0; i < vals.size() && i < push_q.size(); i++) check("push_val", push_q[i], vals[i]);
    check("rsp_cnt", rsp_d.size(), NUM);
    for (int k = 0; k < rsp_d.size() && k < NUM; k++) begin
      check("rsp_data", rsp_d[k], e[k]);
      check("rsp_id", rsp_i[k], owner);
      check("rsp_last", rsp_l[k], k == NUM - 1);
    end
    clear_mon();
  endtask

  task automatic serve(input bit who, input int vals[$], input bit wl, input int gap_at, input int gap_len,
                       input int lat, input int gapk);
    stream(who, vals, wl, gap_at, gap_len);
    engine_run(lat, gapk);
    @(negedge clk);
    check_job(who, vals);
  endtask

  initial begin
    int q[$], a[$], b[$], v12[$];
    bit w, l, o;
    int n, len, ga;
    rst_n = 1'b0;
    req0_valid = 0; req0_last = 0; req0_data = '0;
    req1_valid = 0; req1_last = 0; req1_data = '0;
    eng_out_valid = 0; eng_out = '0;
    rr_m = 0;
    repeat (3) @(negedge clk);
    check("reset_outs", outs(), 0);
    rst_n = 1'b1;
    // basic job from requester 0
    q = {3, 17, 8};
    o = arb(1, 0);
    serve(o, q, 1, 0, 0, 2, 0);
    // simultaneous requests alternate round-robin after a fresh reset
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("reset2_outs", outs(), 0);
    rst_n = 1'b1;
    rr_m = 0;
    for (int r = 0; r < 2; r++) begin
      a.delete(); b.delete();
      for (int i = 0; i < 3; i++) begin
        a.push_back($urandom_range(0, 31));
        b.push_back($urandom_range(0, 31));
      end
      drv(0, 1, a[0], 0);
      drv(1, 1, b[0], 0);
      w = arb(1, 1);
      if (w) serve(1, b, 1, 0, 0, 1, 0); else serve(0, a, 1, 0, 0, 1, 0);
      l = arb(w, !w);
      if (l) serve(1, b, 1, 0, 0, 0, 4); else serve(0, a, 1, 0, 0, 0, 4);
    end
    // 12 values without last: implicit last after NUM, remainder forms next job
    for (int i = 0; i < 12; i++) v12.push_back($urandom_range(0, 31));
    o = arb(0, 1);
    stream(o, v12[0:9], 0, 0, 0);
    drv(1, 1, v12[10], 0);
    check("ready_low_11th", req1_ready, 0);
    engine_run(1, 0);
    @(negedge clk);
    check_job(o, v12[0:9]);
    o = arb(0, 1);
    serve(o, v12[10:11], 1, 0, 0, 0, 0);
    // valid gaps mid-job
    q = {5, 20, 9, 14};
    o = arb(1, 0);
    serve(o, q, 1, 1, 2, 0, 0);
    // engine never answers
    q = {6, 30};
    o = arb(0, 1);
    stream(o, q, 1, 0, 0);
    n = 0;
    while (!(eng_in_valid1 && eng_op == 2'd2) && n < 50) begin @(negedge clk); n++; end
    check("tmo_sort_cmd", 32'(eng_in_valid1 && eng_op == 2'd2), 1);
    n = 0;
    while (!err_tmo && n < 200) begin @(negedge clk); n++; end
    check("tmo_delay", n, 64);
    check("tmo_busy", busy, 1);
    @(negedge clk);
    check("tmo_pulse", err_tmo, 0);
    check("tmo_settle_busy", busy, 1);
    @(negedge clk);
    check("tmo_arb_idle", busy, 0);
    check("tmo_no_rsp", rsp_d.size(), 0);
    check("tmo_push_cnt", push_q.size(), 2);
    clear_mon();
    // reset in the middle of LOAD abandons the job
    q = {4, 13};
    o = arb(1, 0);
    stream(o, q, 0, 0, 0);
    rst_n = 1'b0;
    drv(0, 1, 7, 0);
    @(negedge clk);
    check("rst_mid_outs", outs(), 0);
    rst_n = 1'b1;
    rr_m = 0;
    clear_mon();
    n = 0;
    while (!eng_in_valid2 && n < 20) begin @(negedge clk); n++; end
    drv(0, 0, 0, 0);
    check("rst_settle_grant", n, 4);
    q = {7, 25, 11};
    o = arb(1, 0);
    serve(o, q, 1, 0, 0, 3, 2);
    // randomized jobs
    for (int j = 0; j < 6; j++) begin
      w = 1'($urandom_range(0, 1));
      len = $urandom_range(1, NUM);
      q.delete();
      for (int i = 0; i < len; i++) q.push_back($urandom_range(0, 31));
      ga = (len > 1 && $urandom_range(0, 1) == 1) ? $urandom_range(1, len - 1) : 0;
      o = arb(!w, w);
      serve(o, q, (len < NUM) ? 1'b1 : 1'($urandom_range(0, 1)), ga, $urandom_range(1, 3),
            $urandom_range(0, 5), $urandom_range(0, 9));
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
